play_mode_controller: RTL and testbench

- Parametrised successor to the keyboard top-level mode controller. Selects one of NUM_SRC player sources (free play, auto play, learn, ...) using a one-hot mode input.
- Owns a play/pause/idle state machine driven by the start button. Inserts a muted gap on every mode change.
- Drives registered note, LED, octave and song-number outputs towards the buzzer and display blocks.

---
 rtl/play_pkg.sv | 28 ++
 rtl/play_mode_controller_if.sv | 40 ++++
 rtl/play_mode_controller_onehot_mux.sv | 20 ++
 rtl/play_mode_controller.sv | 148 ++++++++++++++
 tb/tb_play_mode_controller.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/play_pkg.sv
// Shared types and defaults for the play mode controller.
// Holds the FSM state encodings, the rest-note code, the default bus widths
// and a helper that sizes the mute counter.
package play_pkg;

  localparam int unsigned DEF_NUM_SRC     = 3;
  localparam int unsigned DEF_NOTE_W      = 4;
  localparam int unsigned DEF_LED_W       = 7;
  localparam int unsigned DEF_OCT_W       = 2;
  localparam int unsigned DEF_NUM_W       = 4;
  localparam int unsigned DEF_MUTE_CYCLES = 4;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_MUTE  = 2'b11;

  localparam logic [DEF_NOTE_W-1:0] NOTE_REST = '0;

  // Mute counter width; keeps at least one bit when the mute is disabled.
  function automatic int unsigned cnt_width(int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/play_mode_controller_if.sv
// Source/sink bundle of the play mode controller.
// master: drives mode, start and the packed per-source buses, observes outputs.
// slave : the controller itself.
interface play_mode_controller_if
  import play_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned NOTE_W  = DEF_NOTE_W,
  parameter int unsigned LED_W   = DEF_LED_W,
  parameter int unsigned OCT_W   = DEF_OCT_W,
  parameter int unsigned NUM_W   = DEF_NUM_W
) ();

  logic [NUM_SRC-1:0]        mode;
  logic                      start;
  logic [NUM_SRC*NOTE_W-1:0] src_note;
  logic [NUM_SRC*LED_W-1:0]  src_led;
  logic [NUM_SRC*OCT_W-1:0]  src_octave;
  logic [NUM_SRC*NUM_W-1:0]  src_num;
  logic [NUM_SRC-1:0]        src_done;

  logic [NOTE_W-1:0]         note_out;
  logic [LED_W-1:0]          led_out;
  logic [OCT_W-1:0]          octave_out;
  logic [NUM_W-1:0]          num;
  logic [NUM_SRC-1:0]        play_en;
  logic [STATE_W-1:0]        state_out;
  logic                      mode_err;

  modport master (
    output mode, start, src_note, src_led, src_octave, src_num, src_done,
    input  note_out, led_out, octave_out, num, play_en, state_out, mode_err
  );

  modport slave (
    input  mode, start, src_note, src_led, src_octave, src_num, src_done,
    output note_out, led_out, octave_out, num, play_en, state_out, mode_err
  );

endinterface

// File: rtl/play_mode_controller_onehot_mux.sv
// Combinational one-hot selector: ORs together the W-bit lanes of din whose
// sel bit is set. Yields zero when sel is all-zero.
// Ports: sel (N one-hot), din (N*W packed lanes), dout_c (W selected lane).
module onehot_mux #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout_c
);

  always_comb begin
    dout_c = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) dout_c = dout_c | din[i*W +: W];
    end
  end

endmodule

// File: rtl/play_mode_controller.sv
// Keyboard mode controller: picks one of NUM_SRC player sources via a one-hot
// mode, runs the idle/play/pause FSM from the start button and mutes the
// outputs for MUTE_CYCLES after every mode change.
// Ports: clk, reset (sync, active-high), bus (slave side of
// play_mode_controller_if: mode/start/src_* in, note/led/octave/num,
// play_en, state_out, mode_err out, all registered).
module play_mode_controller
  import play_pkg::*;
#(
  parameter int unsigned NUM_SRC     = DEF_NUM_SRC,
  parameter int unsigned FREE_IDX    = 0,
  parameter int unsigned NOTE_W      = DEF_NOTE_W,
  parameter int unsigned LED_W       = DEF_LED_W,
  parameter int unsigned OCT_W       = DEF_OCT_W,
  parameter int unsigned NUM_W       = DEF_NUM_W,
  parameter int unsigned MUTE_CYCLES = DEF_MUTE_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  play_mode_controller_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(MUTE_CYCLES);
  localparam logic [NUM_SRC-1:0] FREE_MASK = NUM_SRC'(1) << FREE_IDX;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 start_q;
  logic                 armed;
  logic [NUM_SRC-1:0]   mode_q;

  logic                 valid_c, rise_c, change_c, done_c;
  logic                 active_c, pass_c;
  logic [NOTE_W-1:0]    note_sel_c;
  logic [LED_W-1:0]     led_sel_c;
  logic [OCT_W-1:0]     oct_sel_c;
  logic [NUM_W-1:0]     num_sel_c;

  logic [NOTE_W-1:0]    note_nxt;
  logic [LED_W-1:0]     led_nxt;
  logic [OCT_W-1:0]     oct_nxt;
  logic [NUM_W-1:0]     num_nxt;
  logic [NUM_SRC-1:0]   play_en_nxt;
  state_t               state_out_nxt;

  onehot_mux #(.N(NUM_SRC), .W(NOTE_W)) u_mux_note (.sel(bus.mode), .din(bus.src_note),   .dout_c(note_sel_c));
  onehot_mux #(.N(NUM_SRC), .W(LED_W))  u_mux_led  (.sel(bus.mode), .din(bus.src_led),    .dout_c(led_sel_c));
  onehot_mux #(.N(NUM_SRC), .W(OCT_W))  u_mux_oct  (.sel(bus.mode), .din(bus.src_octave), .dout_c(oct_sel_c));
  onehot_mux #(.N(NUM_SRC), .W(NUM_W))  u_mux_num  (.sel(bus.mode), .din(bus.src_num),    .dout_c(num_sel_c));

  // Events. armed stays low after reset until start is seen released, so a
  // button held through reset cannot fake a press.
  assign valid_c  = $onehot(bus.mode);
  assign rise_c   = bus.start & ~start_q & armed;
  assign change_c = (bus.mode != mode_q);
  assign done_c   = |(bus.src_done & bus.mode);

  // Next state: mode change first, then invalid mode, then normal transitions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (change_c) begin
      if (MUTE_CYCLES > 0) begin
        state_nxt = ST_MUTE;
        cnt_nxt   = CNT_W'(MUTE_CYCLES);
      end else begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    end else if (!valid_c) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE:  if (rise_c) state_nxt = ST_PLAY;
        ST_PLAY: begin
          if (done_c)      state_nxt = ST_IDLE;
          else if (rise_c) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (rise_c) state_nxt = ST_PLAY;
        ST_MUTE: begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt - CNT_W'(1);
          end
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output values for the next edge, derived from the current state.
  always_comb begin
    active_c      = valid_c && (state != ST_MUTE);
    pass_c        = active_c && ((|(bus.mode & FREE_MASK)) || (state == ST_PLAY));
    note_nxt      = pass_c ? note_sel_c : NOTE_W'(NOTE_REST);
    led_nxt       = pass_c ? led_sel_c : '0;
    oct_nxt       = pass_c ? oct_sel_c : '0;
    num_nxt       = active_c ? num_sel_c : '0;
    play_en_nxt   = '0;
    if (active_c) begin
      play_en_nxt = (bus.mode & FREE_MASK) |
                    (bus.mode & ~FREE_MASK & {NUM_SRC{state == ST_PLAY}});
    end
    state_out_nxt = valid_c ? state : ST_IDLE;
  end

  // FSM and input-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      armed   <= 1'b0;
      mode_q  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_q <= bus.start;
      armed   <= armed | ~bus.start;
      mode_q  <= bus.mode;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.note_out   <= '0;
      bus.led_out    <= '0;
      bus.octave_out <= '0;
      bus.num        <= '0;
      bus.play_en    <= '0;
      bus.state_out  <= ST_IDLE;
      bus.mode_err   <= 1'b0;
    end else begin
      bus.note_out   <= note_nxt;
      bus.led_out    <= led_nxt;
      bus.octave_out <= oct_nxt;
      bus.num        <= num_nxt;
      bus.play_en    <= play_en_nxt;
      bus.state_out  <= state_out_nxt;
      bus.mode_err   <= ~valid_c;
    end
  end

endmodule

// File: tb/tb_play_mode_controller.sv
// Scoreboard bench for play_mode_controller: the stimulus process queues the
// expected output word for a given cycle, a negedge monitor compares it.
module tb_play_mode_controller;
  import play_pkg::*;

  localparam logic [3:0] NOTES [3] = '{4'd5, 4'd9, 4'd3};
  localparam logic [6:0] LEDS  [3] = '{7'h11, 7'h22, 7'h44};
  localparam logic [1:0] OCTS  [3] = '{2'd1, 2'd2, 2'd3};
  localparam logic [3:0] NUMS  [3] = '{4'd4, 4'd6, 4'd8};

  typedef struct packed {
    logic [3:0] note;
    logic [6:0] led;
    logic [1:0] oct;
    logic [3:0] num;
    logic [2:0] pe;
    logic [1:0] st;
    logic       err;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    string       name;
    obs_t        v;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  ent_t        sb[$];
  ent_t        ent;
  obs_t        act;

  play_mode_controller_if #(.NUM_SRC(3), .NOTE_W(4), .LED_W(7), .OCT_W(2), .NUM_W(4)) bus ();

  play_mode_controller #(
    .NUM_SRC(3), .FREE_IDX(0), .NOTE_W(4), .LED_W(7), .OCT_W(2), .NUM_W(4), .MUTE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output word for a given (state, selected source, mode error).
  function automatic obs_t mk(logic [1:0] st, int sel, logic err);
    obs_t o;
    o = '0;
    if (err) begin
      o.err = 1'b1;
      return o;
    end
    o.st = st;
    if (sel < 0 || st == ST_MUTE) return o;
    o.num = NUMS[sel];
    if (sel == 0 || st == ST_PLAY) begin
      o.note = NOTES[sel];
      o.led  = LEDS[sel];
      o.oct  = OCTS[sel];
    end
    if (sel == 0)            o.pe = 3'b001;
    else if (st == ST_PLAY)  o.pe = 3'(1 << sel);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the outputs seen k edges from now (sorted by cycle).
  task automatic want(int unsigned k, string name, logic [1:0] st, int sel, logic err);
    ent_t e;
    int   i;
    e.cyc  = cyc + k;
    e.name = name;
    e.v    = mk(st, sel, err);
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      ent = sb.pop_front();
      act = {bus.note_out, bus.led_out, bus.octave_out, bus.num, bus.play_en, bus.state_out, bus.mode_err};
      n_chk++;
      if (act === ent.v) n_pass++;
      else $display("FAIL %s @cyc %0d: got note=%h led=%h oct=%h num=%h pe=%b st=%b err=%b, required note=%h led=%h oct=%h num=%h pe=%b st=%b err=%b",
                    ent.name, cyc, act.note, act.led, act.oct, act.num, act.pe, act.st, act.err,
                    ent.v.note, ent.v.led, ent.v.oct, ent.v.num, ent.v.pe, ent.v.st, ent.v.err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.mode       = 3'b001;
    bus.start      = 1'b0;
    bus.src_done   = 3'b000;
    bus.src_note   = {NOTES[2], NOTES[1], NOTES[0]};
    bus.src_led    = {LEDS[2], LEDS[1], LEDS[0]};
    bus.src_octave = {OCTS[2], OCTS[1], OCTS[0]};
    bus.src_num    = {NUMS[2], NUMS[1], NUMS[0]};
    repeat (3) tick();
    want(0, "reset", ST_IDLE, -1, 1'b0);

    // Free source passes while idle, then the power-up mode change mutes.
    reset = 1'b0;
    want(1, "free_idle", ST_IDLE, 0, 1'b0);
    for (int k = 2; k <= 5; k++) want(k, "mute_initial", ST_MUTE, 0, 1'b0);
    want(6, "free_after_mute", ST_IDLE, 0, 1'b0);
    repeat (6) tick();

    // Switch to source 1: four muted cycles, then idle with only num shown.
    bus.mode = 3'b010;
    want(1, "chg_idle", ST_IDLE, 1, 1'b0);
    for (int k = 2; k <= 5; k++) want(k, "mute_src1", ST_MUTE, 1, 1'b0);
    want(6, "idle_src1", ST_IDLE, 1, 1'b0);
    repeat (6) tick();

    // Single start pulse -> PLAY.
    bus.start = 1'b1;
    want(1, "pulse_edge", ST_IDLE, 1, 1'b0);
    want(2, "pulse_play", ST_PLAY, 1, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();

    // End of song -> IDLE.
    bus.src_done = 3'b010;
    want(1, "done_edge", ST_PLAY, 1, 1'b0);
    want(2, "done_idle", ST_IDLE, 1, 1'b0);
    tick();
    bus.src_done = 3'b000;
    tick();

    // Held button: exactly one transition to PLAY.
    bus.start = 1'b1;
    want(1, "held_edge", ST_IDLE, 1, 1'b0);
    for (int k = 2; k <= 10; k++) want(k, "held_play", ST_PLAY, 1, 1'b0);
    repeat (10) tick();
    bus.start = 1'b0;
    want(1, "release", ST_PLAY, 1, 1'b0);
    tick();

    // Second press -> PAUSE; done ignored while paused.
    bus.start = 1'b1;
    want(1, "press2_edge", ST_PLAY, 1, 1'b0);
    want(2, "pause", ST_PAUSE, 1, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    bus.src_done = 3'b010;
    want(1, "pause_done", ST_PAUSE, 1, 1'b0);
    want(2, "pause_hold", ST_PAUSE, 1, 1'b0);
    tick();
    bus.src_done = 3'b000;
    tick();

    // Resume, then done and press together: done wins.
    bus.start = 1'b1;
    want(1, "resume_edge", ST_PAUSE, 1, 1'b0);
    want(2, "resume_play", ST_PLAY, 1, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    bus.start    = 1'b1;
    bus.src_done = 3'b010;
    want(1, "done_rise_edge", ST_PLAY, 1, 1'b0);
    want(2, "done_wins", ST_IDLE, 1, 1'b0);
    tick();
    bus.start    = 1'b0;
    bus.src_done = 3'b000;
    tick();

    // Invalid modes: everything zero, mode_err set.
    bus.mode = 3'b011;
    for (int k = 1; k <= 3; k++) want(k, "err_011", ST_IDLE, -1, 1'b1);
    repeat (3) tick();
    bus.mode = 3'b000;
    for (int k = 1; k <= 3; k++) want(k, "err_000", ST_IDLE, -1, 1'b1);
    repeat (3) tick();
    bus.mode = 3'b010;
    want(1, "back_edge", ST_IDLE, 1, 1'b0);
    for (int k = 2; k <= 5; k++) want(k, "back_mute", ST_MUTE, 1, 1'b0);
    want(6, "back_idle", ST_IDLE, 1, 1'b0);
    repeat (6) tick();

    // Reset with counter at 2 and start held through it.
    bus.mode = 3'b001;
    want(1, "chg_to_free", ST_IDLE, 0, 1'b0);
    want(2, "mute_a", ST_MUTE, 0, 1'b0);
    want(3, "mute_b", ST_MUTE, 0, 1'b0);
    repeat (3) tick();
    reset     = 1'b1;
    bus.start = 1'b1;
    want(1, "rst_in_mute", ST_IDLE, -1, 1'b0);
    tick();
    reset = 1'b0;
    want(1, "post_rst", ST_IDLE, 0, 1'b0);
    for (int k = 2; k <= 5; k++) want(k, "post_rst_mute", ST_MUTE, 0, 1'b0);
    for (int k = 6; k <= 10; k++) want(k, "no_spurious", ST_IDLE, 0, 1'b0);
    repeat (10) tick();
    bus.start = 1'b0;
    want(1, "released", ST_IDLE, 0, 1'b0);
    tick();
    bus.start = 1'b1;
    want(1, "rearm_edge", ST_IDLE, 0, 1'b0);
    want(2, "rearmed_play", ST_PLAY, 0, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
      n_chk = n_chk + sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
